// File: rtl/verify_r_frame_loader.sv
// rtl/verify_r_frame_loader.sv - byte-serial R/R' frame loader feeding the 32-byte equality comparator
//
// Purpose:
//   Collects one 64-byte frame (bytes 0..NBYTES-1 -> operand A, the rest -> operand B,
//   little-endian within each operand). It presents both operands to an external
//   constant-time comparator and samples its diff flag. It then returns a single
//   pass/fail/error result, and wipes both operands when that result is consumed.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous abort: full reset state at the next edge
//   in_valid/in_ready byte stream handshake; in_data byte, in_last end-of-frame marker
//   cmp_a, cmp_b      assembled operands to the comparator
//   cmp_diff          comparator result, 1 = operands differ
//   res_valid/res_ready result handshake; res_ok = equal and well-formed, res_err = framing error
//   busy              frame in progress or result pending

module verify_r_frame_loader #(
    parameter int NBYTES = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic [8*NBYTES-1:0]   cmp_a,
    output logic [8*NBYTES-1:0]   cmp_b,
    input  logic                  cmp_diff,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_ok,
    output logic                  res_err,
    output logic                  busy
);

    localparam int OPW   = 8 * NBYTES;
    localparam int IDX_W = $clog2(OPW);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(2 * NBYTES - 1);
    localparam logic [CNT_W-1:0] K_SPLIT = CNT_W'(NBYTES);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CMP    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [OPW-1:0]     a_q, a_d;
    logic [OPW-1:0]     b_q, b_d;
    logic               err_q, err_d;
    logic               rv_q, rv_d;
    logic               ok_q, ok_d;
    logic               re_q, re_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   k_b;
    logic [IDX_W-1:0]   a_idx;
    logic [IDX_W-1:0]   b_idx;
    logic               k_is_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            ok_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            ok_q    <= ok_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        err_d     = err_q;
        rv_d      = rv_q;
        ok_d      = ok_q;
        re_d      = re_q;
        k_b       = k_q - K_SPLIT;
        a_idx     = IDX_W'({k_q, 3'b000});
        b_idx     = IDX_W'({k_b, 3'b000});
        k_is_last = (k_q == K_LAST);

        if (clear) begin
            state_d = ST_LOAD;
            k_d     = '0;
            a_d     = '0;
            b_d     = '0;
            err_d   = 1'b0;
            rv_d    = 1'b0;
            ok_d    = 1'b0;
            re_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (k_q < K_SPLIT) begin
                            a_d[a_idx +: 8] = in_data;
                        end else begin
                            b_d[b_idx +: 8] = in_data;
                        end
                        if (in_last || k_is_last) begin
                            // A frame is well-formed only when the marker and the
                            // final slot coincide; any other ending latches an error.
                            err_d   = err_q | (in_last != k_is_last);
                            k_d     = '0;
                            state_d = ST_CMP;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                ST_CMP: begin
                    // Same single cycle for every frame, so latency never depends on data.
                    ok_d    = ~cmp_diff & ~err_q;
                    re_d    = err_q;
                    rv_d    = 1'b1;
                    state_d = ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        rv_d    = 1'b0;
                        ok_d    = 1'b0;
                        re_d    = 1'b0;
                        a_d     = '0;
                        b_d     = '0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end

        busy_d = (state_d != ST_LOAD) || (k_d != '0);
    end

    // Decoded from state only, so there is no path from in_valid back to in_ready.
    assign in_ready  = (state_q == ST_LOAD);
    assign cmp_a     = a_q;
    assign cmp_b     = b_q;
    assign res_valid = rv_q;
    assign res_ok    = ok_q;
    assign res_err   = re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_verify_r_frame_loader.sv
// tb/tb_verify_r_frame_loader.sv - self-checking bench for verify_r_frame_loader

module tb_verify_r_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic [255:0] cmp_a;
    logic [255:0] cmp_b;
    logic         cmp_diff;
    logic         res_valid;
    logic         res_ready;
    logic         res_ok;
    logic         res_err;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the constant-time comparator.
    assign cmp_diff = (cmp_a != cmp_b);

    verify_r_frame_loader #(.NBYTES(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_diff  (cmp_diff),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_err   (res_err),
        .busy      (busy)
    );

    typedef struct {
        string      name;
        int         last_at;   // byte index carrying in_last, -1 = never
        int         b_idx;     // B byte to override, -1 = none
        logic [7:0] b_val;
        logic       exp_ok;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int last_at, input int b_idx, input logic [7:0] b_val);
        int n;
        logic [7:0] d;
        n = (last_at >= 0) ? last_at + 1 : 64;
        for (int j = 0; j < n; j++) begin
            d = (j < 32) ? 8'(j) : 8'(j - 32);
            if (j >= 32 && (j - 32) == b_idx) d = b_val;
            send_byte(d, j == last_at);
        end
    endtask

    // Edges after the final-byte handshake edge until res_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ref_lat;

        vecs[0] = '{"equal",        63, -1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{"b31_differs",  63, 31, 8'h9F, 1'b0, 1'b0};
        vecs[2] = '{"b0_differs",   63,  0, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{"early_last40", 40, -1, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{"equal_after",  63, -1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{"no_last",      -1, -1, 8'h00, 1'b0, 1'b1};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; res_ready = 1'b0;
        #12;
        check("rst_res_valid", 256'(res_valid), 256'(1'b0));
        check("rst_res_ok",    256'(res_ok),    256'(1'b0));
        check("rst_res_err",   256'(res_err),   256'(1'b0));
        check("rst_busy",      256'(busy),      256'(1'b0));
        check("rst_in_ready",  256'(in_ready),  256'(1'b1));
        check("rst_cmp_a",     cmp_a,           256'(0));
        check("rst_cmp_b",     cmp_b,           256'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven frames, consumer always ready.
        ref_lat = 1;
        for (int i = 0; i < 6; i++) begin
            res_ready = 1'b1;
            send_frame(vecs[i].last_at, vecs[i].b_idx, vecs[i].b_val);
            wait_result(lat);
            check({vecs[i].name, "_latency"}, 256'(lat), 256'(ref_lat));
            check({vecs[i].name, "_valid"},   256'(res_valid), 256'(1'b1));
            check({vecs[i].name, "_ok"},      256'(res_ok), 256'(vecs[i].exp_ok));
            check({vecs[i].name, "_err"},     256'(res_err), 256'(vecs[i].exp_err));
            if (i == 0) begin
                check("equal_a_lo", 256'(cmp_a[7:0]),     256'(8'h00));
                check("equal_a_hi", 256'(cmp_a[255:248]), 256'(8'h1F));
                check("equal_b_hi", 256'(cmp_b[255:248]), 256'(8'h1F));
            end
            @(posedge clk);
            #1;
            check({vecs[i].name, "_valid_drop"}, 256'(res_valid), 256'(1'b0));
            check({vecs[i].name, "_wipe_a"},     cmp_a, 256'(0));
            check({vecs[i].name, "_wipe_b"},     cmp_b, 256'(0));
            check({vecs[i].name, "_idle"},       256'(busy), 256'(1'b0));
        end

        // Backpressured result with bytes offered during RESULT.
        res_ready = 1'b0;
        send_frame(63, -1, 8'h00);
        wait_result(lat);
        check("hold_latency", 256'(lat), 256'(ref_lat));
        in_valid = 1'b1;
        in_data  = 8'hAB;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid",    256'(res_valid),   256'(1'b1));
            check("hold_ok",       256'(res_ok),      256'(1'b1));
            check("hold_err",      256'(res_err),     256'(1'b0));
            check("hold_in_ready", 256'(in_ready),    256'(1'b0));
            check("hold_a_byte0",  256'(cmp_a[7:0]),  256'(8'h00));
            check("hold_b_hi",     256'(cmp_b[255:248]), 256'(8'h1F));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_valid",    256'(res_valid), 256'(1'b0));
        check("hs_wipe_a",   cmp_a, 256'(0));
        check("hs_wipe_b",   cmp_b, 256'(0));
        check("hs_in_ready", 256'(in_ready), 256'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("first_byte_taken", 256'(cmp_a[7:0]), 256'(8'hAB));
        check("first_byte_busy",  256'(busy), 256'(1'b1));

        // Continue to byte 45, then clear with a byte presented in the same cycle.
        for (int j = 1; j <= 45; j++) send_byte(8'(j | 8'h40), 1'b0);
        check("pre_clear_busy", 256'(busy), 256'(1'b1));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_cmp_a",    cmp_a, 256'(0));
        check("clear_cmp_b",    cmp_b, 256'(0));
        check("clear_busy",     256'(busy), 256'(1'b0));
        check("clear_in_ready", 256'(in_ready), 256'(1'b1));
        check("clear_valid",    256'(res_valid), 256'(1'b0));

        // Asynchronous reset after byte 20.
        for (int j = 0; j <= 20; j++) send_byte(8'(j + 1), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",     256'(busy), 256'(1'b0));
        check("arst_cmp_a",    cmp_a, 256'(0));
        check("arst_in_ready", 256'(in_ready), 256'(1'b1));
        check("arst_valid",    256'(res_valid), 256'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send_frame(63, -1, 8'h00);
        wait_result(lat);
        check("post_rst_latency", 256'(lat), 256'(ref_lat));
        check("post_rst_ok",      256'(res_ok), 256'(1'b1));
        check("post_rst_err",     256'(res_err), 256'(1'b0));
        @(posedge clk);
        #1;
        check("post_rst_drop",    256'(res_valid), 256'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
